// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the systolic-array input FIFO. Drains burst_len words
// through the FIFO read port and re-presents them on a valid/ready stream.
module fifo_burst_reader #(
  parameter int FIFO_DATA_WIDTH = 20,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       burst_len,
  output logic                       fifo_readp,
  input  logic                       fifo_emptyp,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_data_out,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done,
  output logic [LEN_WIDTH-1:0]       rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                     state;
  logic [LEN_WIDTH-1:0]       len;
  logic [LEN_WIDTH-1:0]       issued;
  logic                       inflight;
  logic [1:0]                 occ;
  logic [FIFO_DATA_WIDTH-1:0] buf_head;
  logic [FIFO_DATA_WIDTH-1:0] buf_tail;
  logic                       pop;
  logic                       push;
  logic [2:0]                 credit;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;
  assign busy    = (state != IDLE);
  assign pop     = m_valid && m_ready;
  assign push    = inflight;

  // A read may only issue if the word it returns next cycle is guaranteed a buffer slot.
  assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_readp = (state == RUN) && !fifo_emptyp && (issued < len) && (credit < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
      done     <= 1'b0;
      rd_count <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_readp;

      assert (!(push && !pop && occ == 2'd2));

      // Word returned by the FIFO lands behind whatever survives this cycle's pop.
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) buf_head <= fifo_data_out;
          else             buf_tail <= fifo_data_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= fifo_data_out;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data_out;
          end
        end
        default: ;
      endcase

      if (fifo_readp) issued <= issued + ONE;
      if (pop)        rd_count <= rd_count + ONE;

      unique case (state)
        IDLE: begin
          if (start) begin
            rd_count <= '0;
            if (burst_len != '0) begin
              len    <= burst_len;
              issued <= '0;
              state  <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fifo_readp && (issued + ONE == len)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (rd_count + ONE == len)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a behavioural FIFO feeds the DUT and a
// monitor checks every delivered word against hand-computed expectations.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  burst_len;
  logic        fifo_readp;
  logic        fifo_emptyp = 1'b1;
  logic [19:0] fifo_data_out = '0;
  logic [19:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic [7:0]  rd_count;

  logic        wr_en = 1'b0;
  logic [19:0] wr_data = '0;

  logic [19:0] fifo_q[$];
  logic [19:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          readp_err = 0;
  bit          pat[4];

  fifo_burst_reader #(.FIFO_DATA_WIDTH(20), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_readp(fifo_readp), .fifo_emptyp(fifo_emptyp), .fifo_data_out(fifo_data_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Source FIFO with one-cycle registered read data; not affected by the DUT reset.
  always @(posedge clk) begin
    if (fifo_readp && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_emptyp <= (fifo_q.size() == 0);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) check_output("unexpected_word", 32'(m_data), 32'hFFFFFFFF);
      else check_output("word", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (done === 1'b1) done_cnt++;
    if (fifo_readp === 1'b1 && fifo_emptyp === 1'b1) readp_err++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] base, input int n);
    for (int i = 1; i <= n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 20'(i);
      step();
    end
    wr_en = 1'b0;
    step();
  endtask

  // Queue the words this burst should deliver, then pulse start for one cycle.
  task automatic apply_stimulus(input logic [7:0] len, input logic [19:0] first_exp, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_q.push_back(first_exp + 20'(i));
    start     = 1'b1;
    burst_len = len;
    step();
    start     = 1'b0;
    burst_len = 8'd0;
  endtask

  task automatic run_until_done(input int max_cyc, input bit toggle, output int done_cyc,
                                output int first_valid, output logic busy_at_done);
    done_cyc     = -1;
    first_valid  = -1;
    busy_at_done = 1'bx;
    for (int c = 1; c <= max_cyc; c++) begin
      m_ready = toggle ? pat[(c - 1) % 4] : 1'b1;
      @(negedge clk);
      if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (done === 1'b1) begin
        done_cyc     = c;
        busy_at_done = busy;
        break;
      end
      step();
    end
    if (done_cyc < 0) check_output("done_timeout", 32'd0, 32'd1);
    else step();
    m_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   dc, fv, d0;
    logic bd;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst = 1'b1; start = 1'b0; burst_len = 8'd0; m_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_m_data", 32'(m_data), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_rd_count", 32'(rd_count), 32'd0);
    check_output("rst_readp", 32'(fifo_readp), 32'd0);
    step();
    rst = 1'b0;

    // Back-to-back burst of 5 with no stalls
    preload(20'h00000, 5);
    apply_stimulus(8'd5, 20'h00001, 5);
    run_until_done(40, 1'b0, dc, fv, bd);
    check_output("t1_first_valid_cycle", 32'(fv), 32'd3);
    check_output("t1_done_cycle", 32'(dc), 32'd8);
    check_output("t1_busy_at_done", 32'(bd), 32'd0);
    check_output("t1_rd_count", 32'(rd_count), 32'd5);
    check_output("t1_exp_empty", 32'(exp_q.size()), 32'd0);

    // Burst of 8 under a 1,0,0,1 ready pattern
    preload(20'h00200, 8);
    apply_stimulus(8'd8, 20'h00201, 8);
    run_until_done(200, 1'b1, dc, fv, bd);
    check_output("t2_rd_count", 32'(rd_count), 32'd8);
    check_output("t2_exp_empty", 32'(exp_q.size()), 32'd0);

    // Start on an empty FIFO; words trickle in later
    exp_q.push_back(20'hABCDE);
    exp_q.push_back(20'h12345);
    exp_q.push_back(20'h0F0F0);
    apply_stimulus(8'd3, 20'h0, 0);
    dc = -1;
    for (int c = 1; c <= 80; c++) begin
      wr_en   = (c == 10) || (c == 15) || (c == 16);
      wr_data = (c == 10) ? 20'hABCDE : (c == 15) ? 20'h12345 : 20'h0F0F0;
      @(negedge clk);
      if (c == 8) begin
        check_output("t3_busy_waiting", 32'(busy), 32'd1);
        check_output("t3_readp_waiting", 32'(fifo_readp), 32'd0);
      end
      if (done === 1'b1) begin
        dc = c;
        break;
      end
      step();
    end
    wr_en = 1'b0;
    if (dc < 0) check_output("t3_done_timeout", 32'd0, 32'd1);
    step();
    check_output("t3_rd_count", 32'(rd_count), 32'd3);
    check_output("t3_exp_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length burst
    apply_stimulus(8'd0, 20'h0, 0);
    @(negedge clk);
    check_output("t4_done", 32'(done), 32'd1);
    check_output("t4_busy", 32'(busy), 32'd0);
    check_output("t4_readp", 32'(fifo_readp), 32'd0);
    check_output("t4_rd_count", 32'(rd_count), 32'd0);
    step();
    @(negedge clk);
    check_output("t4_done_one_cycle", 32'(done), 32'd0);
    check_output("t4_busy_after", 32'(busy), 32'd0);
    step();

    // Reset after two pops; reads issued at cycles 1..4 consume 0x101..0x104
    preload(20'h00100, 6);
    apply_stimulus(8'd6, 20'h00101, 2);
    step(); step(); step(); step();
    m_ready = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_output("t5_m_valid_after_rst", 32'(m_valid), 32'd0);
    check_output("t5_busy_after_rst", 32'(busy), 32'd0);
    check_output("t5_rd_count_after_rst", 32'(rd_count), 32'd0);
    check_output("t5_pre_rst_words", 32'(exp_q.size()), 32'd0);
    step();
    m_ready = 1'b1;
    apply_stimulus(8'd2, 20'h00105, 2);
    run_until_done(40, 1'b0, dc, fv, bd);
    check_output("t5_rd_count", 32'(rd_count), 32'd2);
    check_output("t5_exp_empty", 32'(exp_q.size()), 32'd0);
    check_output("t5_fifo_left", 32'(fifo_q.size()), 32'd0);

    // Second start while busy must be ignored
    preload(20'h00300, 5);
    d0 = done_cnt;
    apply_stimulus(8'd3, 20'h00301, 3);
    step();
    start     = 1'b1;
    burst_len = 8'd4;
    step();
    start     = 1'b0;
    burst_len = 8'd0;
    run_until_done(40, 1'b0, dc, fv, bd);
    step(); step(); step(); step();
    check_output("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_output("t6_rd_count", 32'(rd_count), 32'd3);
    check_output("t6_fifo_left", 32'(fifo_q.size()), 32'd2);
    check_output("t6_exp_empty", 32'(exp_q.size()), 32'd0);
    check_output("t6_busy", 32'(busy), 32'd0);

    check_output("readp_while_empty", 32'(readp_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
